// File: rtl/ms_pattern_sequencer.sv
// Pattern sequencer: plays pattern memory words on port_ms_o with per-step hold,
// pass looping, optional input trigger and per-step capture of the synchronized input.
module ms_pattern_sequencer #(
  parameter int         DEPTH       = 16,
  parameter int         ADDR_W      = $clog2(DEPTH),
  parameter int         HOLD_W      = 16,
  parameter logic [7:0] IDLE_VAL    = 8'h00,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pat_we,
  input  logic [ADDR_W-1:0] pat_addr,
  input  logic [7:0]        pat_wdata,
  input  logic [ADDR_W-1:0] cfg_len,
  input  logic [HOLD_W-1:0] cfg_hold,
  input  logic [7:0]        cfg_loops,
  input  logic              cfg_trig_en,
  input  logic              start,
  input  logic              stop,
  input  logic              port_ms_i,
  output logic [7:0]        port_ms_o,
  output logic              step_stb,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [7:0]        cap_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [7:0] pat_mem [DEPTH];

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   ms_prev_reg;
  logic                   ms_s;
  logic                   ms_rise;

  logic [ADDR_W-1:0] step_reg, step_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [7:0]        loop_cnt_reg, loop_cnt_next;

  logic [ADDR_W-1:0] len_reg, len_next;
  logic [HOLD_W-1:0] hold_reg, hold_next;
  logic [7:0]        loops_reg, loops_next;

  logic [7:0] out_reg, out_next;
  logic       stb_reg, stb_next;
  logic       done_reg, done_next;
  logic       aborted_reg, aborted_next;
  logic [7:0] cap_reg, cap_next;

  // Pattern memory is deliberately not reset; the run reads it only at step entry.
  always_ff @(posedge clk) begin
    if (pat_we) begin
      pat_mem[pat_addr] <= pat_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_reg    <= '0;
      ms_prev_reg <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[SYNC_STAGES-2:0], port_ms_i};
      ms_prev_reg <= ms_s;
    end
  end

  assign ms_s    = sync_reg[SYNC_STAGES-1];
  assign ms_rise = ms_s & ~ms_prev_reg;

  always_comb begin
    state_next    = state_reg;
    step_next     = step_reg;
    hold_cnt_next = hold_cnt_reg;
    loop_cnt_next = loop_cnt_reg;
    len_next      = len_reg;
    hold_next     = hold_reg;
    loops_next    = loops_reg;
    out_next      = IDLE_VAL;
    stb_next      = 1'b0;
    done_next     = 1'b0;
    aborted_next  = 1'b0;
    cap_next      = cap_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (start && !stop) begin
          len_next      = cfg_len;
          hold_next     = cfg_hold;
          loops_next    = cfg_loops;
          cap_next      = '0;
          step_next     = '0;
          hold_cnt_next = '0;
          loop_cnt_next = '0;
          if (cfg_trig_en) begin
            state_next = ST_ARM;
          end else begin
            state_next = ST_RUN;
            out_next   = pat_mem[0];
            stb_next   = 1'b1;
          end
        end
      end

      ST_ARM: begin
        if (stop) begin
          state_next   = ST_IDLE;
          aborted_next = 1'b1;
        end else if (ms_rise) begin
          state_next = ST_RUN;
          out_next   = pat_mem[0];
          stb_next   = 1'b1;
        end
      end

      ST_RUN: begin
        if (stop) begin
          state_next   = ST_IDLE;
          aborted_next = 1'b1;
        end else begin
          out_next = out_reg;
          if (hold_cnt_reg == hold_reg) begin
            // Last cycle of the step: sample input, then pick the next step.
            cap_next      = {cap_reg[6:0], ms_s};
            hold_cnt_next = '0;
            if (step_reg < len_reg) begin
              step_next = step_reg + 1'b1;
              out_next  = pat_mem[step_next];
              stb_next  = 1'b1;
            end else if (loop_cnt_reg < loops_reg) begin
              step_next     = '0;
              loop_cnt_next = loop_cnt_reg + 1'b1;
              out_next      = pat_mem[0];
              stb_next      = 1'b1;
            end else begin
              state_next = ST_DONE;
              done_next  = 1'b1;
              out_next   = IDLE_VAL;
            end
          end else begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      step_reg     <= '0;
      hold_cnt_reg <= '0;
      loop_cnt_reg <= '0;
      len_reg      <= '0;
      hold_reg     <= '0;
      loops_reg    <= '0;
      out_reg      <= IDLE_VAL;
      stb_reg      <= 1'b0;
      done_reg     <= 1'b0;
      aborted_reg  <= 1'b0;
      cap_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      step_reg     <= step_next;
      hold_cnt_reg <= hold_cnt_next;
      loop_cnt_reg <= loop_cnt_next;
      len_reg      <= len_next;
      hold_reg     <= hold_next;
      loops_reg    <= loops_next;
      out_reg      <= out_next;
      stb_reg      <= stb_next;
      done_reg     <= done_next;
      aborted_reg  <= aborted_next;
      cap_reg      <= cap_next;
    end
  end

  assign port_ms_o = out_reg;
  assign step_stb  = stb_reg;
  assign busy      = (state_reg == ST_ARM) || (state_reg == ST_RUN);
  assign done      = done_reg;
  assign aborted   = aborted_reg;
  assign cap_data  = cap_reg;

endmodule
